// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetch (m0) and load/store (m1) onto one memory slave port.
// Optional slave-ack timeout is compiled in when ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_i,
  input  logic [AW-1:0] m0_addr_i,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_done_o,
  output logic          m0_err_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_done_o,
  output logic          m1_err_o,
  output logic          s_req_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_wdata_o,
  input  logic [DW-1:0] s_rdata_i,
  input  logic          s_ack_i,
  output logic          hold_flag_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  logic [1:0] state;
  logic       last_gnt;
  logic       req0;
  logic       req1;
  logic       pick1;
  logic       timeout_hit;

  // A master keeps req high through its done cycle, so that cycle must not re-grant it.
  assign req0  = m0_req_i & ~m0_done_o;
  assign req1  = m1_req_i & ~m1_done_o;
  assign pick1 = req1 & (~req0 | ~last_gnt);

  assign hold_flag_o = rst & m1_req_i & ~m1_done_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_gnt   <= 1'b0;
      s_req_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      m0_rdata_o <= '0;
      m1_rdata_o <= '0;
      m0_done_o  <= 1'b0;
      m1_done_o  <= 1'b0;
    end else begin
      // NOTE: done defaults low every cycle and is only set on completion, giving a one-cycle pulse.
      m0_done_o <= 1'b0;
      m1_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            s_req_o <= 1'b1;
            if (pick1) begin
              state     <= BUSY1;
              s_we_o    <= m1_we_i;
              s_addr_o  <= m1_addr_i;
              s_wdata_o <= m1_wdata_i;
            end else begin
              state     <= BUSY0;
              s_we_o    <= 1'b0;
              s_addr_o  <= m0_addr_i;
              s_wdata_o <= '0;
            end
          end
        end
        BUSY0: begin
          if (s_ack_i || timeout_hit) begin
            s_req_o    <= 1'b0;
            m0_done_o  <= 1'b1;
            m0_rdata_o <= s_ack_i ? s_rdata_i : '0;
            last_gnt   <= 1'b0;
            state      <= IDLE;
          end
        end
        BUSY1: begin
          if (s_ack_i) begin
            s_req_o   <= 1'b0;
            m1_done_o <= 1'b1;
            if (!s_we_o) m1_rdata_o <= s_rdata_i;
            last_gnt  <= 1'b1;
            state     <= IDLE;
          end else if (timeout_hit) begin
            s_req_o    <= 1'b0;
            m1_done_o  <= 1'b1;
            m1_rdata_o <= '0;
            last_gnt   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] wait_cnt;
  logic          err0;
  logic          err1;

  // An ack arriving in the final allowed cycle takes priority over the timeout.
  assign timeout_hit = (state != IDLE) && (wait_cnt == CW'(TIMEOUT - 1)) && !s_ack_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err0     <= 1'b0;
      err1     <= 1'b0;
    end else begin
      err0 <= 1'b0;
      err1 <= 1'b0;
      if (state == IDLE || s_ack_i) begin
        wait_cnt <= '0;
      end else if (timeout_hit) begin
        wait_cnt <= '0;
        err0     <= (state == BUSY0);
        err1     <= (state == BUSY1);
      end else begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  assign m0_err_o = err0;
  assign m1_err_o = err1;
`else
  assign timeout_hit = 1'b0;
  assign m0_err_o    = 1'b0;
  assign m1_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus, a transaction-level reference model checked every cycle,
// and literal expectations for each scenario. Honours ARB_TIMEOUT_EN if defined.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_done;
  logic          m0_err;
  logic          m1_req = 1'b0;
  logic          m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_done;
  logic          m1_err;
  logic          s_req;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata = '0;
  logic          s_ack = 1'b0;
  logic          hold_flag;

  int n_checks = 0;
  int n_errors = 0;

  int ack_wait  = 0;
  bit never_ack = 1'b0;
  bit stray_ack = 1'b0;
  int slave_cnt = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_rdata_o(m0_rdata), .m0_done_o(m0_done), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(m1_rdata), .m1_done_o(m1_done), .m1_err_o(m1_err),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rdata_i(s_rdata), .s_ack_i(s_ack), .hold_flag_o(hold_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int m, input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      seen = (m == 1) ? m1_done : m0_done;
    end
  endtask

  // Slave: acks after ack_wait extra cycles of s_req, in the same cycle (combinational-style).
  always begin
    @(posedge clk);
    #1;
    if (s_req) begin
      s_ack = !never_ack && (slave_cnt == ack_wait);
      slave_cnt++;
    end else begin
      s_ack     = stray_ack;
      slave_cnt = 0;
    end
  end

  // Reference model: who owns the slave port, what it must show next cycle.
  int            owner = -1;
  int            last  = 0;
  logic          e_sreq = 1'b0, e_swe = 1'b0;
  logic [AW-1:0] e_saddr = '0;
  logic [DW-1:0] e_swdata = '0, e_rdata0 = '0, e_rdata1 = '0;
  logic          e_done0 = 1'b0, e_done1 = 1'b0, e_err0 = 1'b0, e_err1 = 1'b0;
`ifdef ARB_TIMEOUT_EN
  int            busy = 0;
`endif

  always @(negedge clk) begin
    if (!rst) begin
      check("mdl_rst_sreq", s_req, 0);
      check("mdl_rst_done0", m0_done, 0);
      check("mdl_rst_done1", m1_done, 0);
      check("mdl_rst_hold", hold_flag, 0);
      check("mdl_rst_rdata0", m0_rdata, 0);
      check("mdl_rst_rdata1", m1_rdata, 0);
      check("mdl_rst_saddr", s_addr, 0);
      owner = -1; last = 0;
      e_sreq = 0; e_swe = 0; e_saddr = '0; e_swdata = '0;
      e_rdata0 = '0; e_rdata1 = '0; e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0;
    end else begin
      bit r0, r1;
      int win;
      check("mdl_sreq", s_req, e_sreq);
      check("mdl_swe", s_we, e_swe);
      check("mdl_saddr", s_addr, e_saddr);
      check("mdl_swdata", s_wdata, e_swdata);
      check("mdl_done0", m0_done, e_done0);
      check("mdl_done1", m1_done, e_done1);
      check("mdl_err0", m0_err, e_err0);
      check("mdl_err1", m1_err, e_err1);
      check("mdl_rdata0", m0_rdata, e_rdata0);
      check("mdl_rdata1", m1_rdata, e_rdata1);
      check("mdl_hold", hold_flag, m1_req && !e_done1);
      r0 = m0_req && !e_done0;
      r1 = m1_req && !e_done1;
      e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0;
      if (owner < 0) begin
        win = -1;
        if (r0 && r1) win = (last == 1) ? 0 : 1;
        else if (r1)  win = 1;
        else if (r0)  win = 0;
        if (win >= 0) begin
          owner    = win;
          e_sreq   = 1;
          e_saddr  = (win == 1) ? m1_addr : m0_addr;
          e_swe    = (win == 1) ? m1_we : 1'b0;
          e_swdata = (win == 1) ? m1_wdata : '0;
`ifdef ARB_TIMEOUT_EN
          busy = 0;
`endif
        end
      end else if (s_ack) begin
        e_sreq = 0;
        if (owner == 0) begin
          e_done0 = 1; e_rdata0 = s_rdata;
        end else begin
          e_done1 = 1;
          if (!e_swe) e_rdata1 = s_rdata;
        end
        last  = owner;
        owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (busy == TIMEOUT - 1) begin
        e_sreq = 0;
        if (owner == 0) begin e_done0 = 1; e_err0 = 1; e_rdata0 = '0; end
        else            begin e_done1 = 1; e_err1 = 1; e_rdata1 = '0; end
        last  = owner;
        owner = -1;
      end else begin
        busy++;
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            cyc;
    bit            seen;
    int            ng;
    logic          prev;
    logic [AW-1:0] grants [4];

    repeat (2) tick();
    rst = 1'b1;
    tick();

    // 1: single fetch read, ack in the s_req cycle
    s_rdata = 32'h0050_0093; m0_addr = 32'h10; m0_req = 1'b1;
    tick();
    check("t1_sreq", s_req, 1);
    check("t1_saddr", s_addr, 32'h10);
    check("t1_swe", s_we, 0);
    check("t1_early_done", m0_done, 0);
    tick();
    check("t1_done", m0_done, 1);
    check("t1_rdata", m0_rdata, 32'h0050_0093);
    check("t1_hold", hold_flag, 0);
    m0_req = 1'b0;
    tick();
    check("t1_pulse", m0_done, 0);

    // 2: contention from reset, both held
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h20; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    s_rdata = 32'h1234;
    tick();
    rst = 1'b1;
    ng = 0; prev = 1'b0;
    for (int i = 0; i < 20 && ng < 4; i++) begin
      tick();
      if (s_req && !prev) begin
        grants[ng] = s_addr;
        ng++;
      end
      prev = s_req;
    end
    check("t2_ngrants", ng, 4);
    check("t2_g0", grants[0], 32'h200);
    check("t2_g1", grants[1], 32'h20);
    check("t2_g2", grants[2], 32'h200);
    check("t2_g3", grants[3], 32'h20);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) tick();

    // 3: write with three wait cycles
    check("t3_prev_rdata", m1_rdata, 32'h1234);
    ack_wait = 3; s_rdata = 32'hDEAD;
    m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'hCAFE; m1_req = 1'b1;
    #1;
    check("t3_hold_idle", hold_flag, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_sreq", s_req, 1);
      check("t3_saddr", s_addr, 32'h100);
      check("t3_swe", s_we, 1);
      check("t3_swdata", s_wdata, 32'hCAFE);
      check("t3_hold", hold_flag, 1);
      check("t3_nodone", m1_done, 0);
    end
    tick();
    check("t3_done", m1_done, 1);
    check("t3_hold_done", hold_flag, 0);
    check("t3_rdata_kept", m1_rdata, 32'h1234);
    m1_req = 1'b0; m1_we = 1'b0; ack_wait = 0;
    tick();

    // 4: async reset mid-BUSY1
    never_ack = 1'b1; m1_addr = 32'h300; m1_req = 1'b1;
    tick();
    check("t4_busy", s_req, 1);
    check("t4_hold", hold_flag, 1);
    #1 rst = 1'b0;
    #1;
    check("t4_sreq_async", s_req, 0);
    check("t4_hold_async", hold_flag, 0);
    m1_req = 1'b0; never_ack = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_done", m1_done, 0);
      check("t4_idle", s_req, 0);
    end

    // 5: ack with a pending request, then a stray ack in IDLE
    s_rdata = 32'h1111_1111; m0_addr = 32'h40; m0_req = 1'b1;
    tick();
    check("t5_m0_sreq", s_req, 1);
    check("t5_m0_addr", s_addr, 32'h40);
    m1_addr = 32'h140; m1_we = 1'b0; m1_req = 1'b1;
    tick();
    check("t5_m0_done", m0_done, 1);
    check("t5_gap", s_req, 0);
    m0_req = 1'b0; s_rdata = 32'h2222_2222;
    tick();
    check("t5_m1_sreq", s_req, 1);
    check("t5_m1_addr", s_addr, 32'h140);
    tick();
    check("t5_m1_done", m1_done, 1);
    check("t5_m1_rdata", m1_rdata, 32'h2222_2222);
    check("t5_m0_rdata", m0_rdata, 32'h1111_1111);
    m1_req = 1'b0; stray_ack = 1'b1; s_rdata = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stray_sreq", s_req, 0);
      check("t5_stray_done0", m0_done, 0);
      check("t5_stray_done1", m1_done, 0);
      check("t5_stray_rdata1", m1_rdata, 32'h2222_2222);
    end
    stray_ack = 1'b0;
    tick();

    // 6: slave never acks
    never_ack = 1'b1; m0_addr = 32'h50; m0_req = 1'b1;
`ifdef ARB_TIMEOUT_EN
    wait_done(0, 40, cyc, seen);
    check("t6_seen", seen, 1);
    check("t6_cycles", cyc, 17);
    check("t6_err", m0_err, 1);
    check("t6_rdata", m0_rdata, 0);
    m0_req = 1'b0; never_ack = 1'b0;
    repeat (2) tick();
`else
    wait_done(0, 100, cyc, seen);
    check("t6_no_done", seen, 0);
    check("t6_still_busy", s_req, 1);
    check("t6_err", m0_err, 0);
    rst = 1'b0; m0_req = 1'b0; never_ack = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
